// File: rtl/mul_sequencer.sv
// mul_sequencer: drives the radix-4 Booth multiplier core for RV32M MUL/MULH/MULHSU/MULHU.
// Ports: clk, rst (async, active-high), req_* (valid/ready), flush, rsp_* (valid/ready),
//   core_start/core_a/core_b out and core_done/core_product in.
// Option: define MUL_RESULT_CACHE_EN to reuse the last completed, unflushed product.
module mul_sequencer #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  localparam int CORE_W = XLEN + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [XLEN-1:0]       req_a,
  input  logic [XLEN-1:0]       req_b,
  input  logic [TAG_W-1:0]      req_tag,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_data,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  core_start,
  output logic [CORE_W-1:0]     core_a,
  output logic [CORE_W-1:0]     core_b,
  input  logic                  core_done,
  input  logic [2*CORE_W-1:0]   core_product
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic              a_sgn;
  logic              b_sgn;
  logic              accept;
  logic              cap;
  logic              rsp_hs;
  logic              hit;
  logic              lo_q;
  logic [CORE_W-1:0] a_ext;
  logic [CORE_W-1:0] b_ext;
  logic [XLEN-1:0]   hit_data;
  logic [XLEN-1:0]   prod_lo;
  logic [XLEN-1:0]   prod_hi;
  logic              unused_prod;

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign core_start = (state_q == ISSUE);

  assign a_sgn = (req_op == 2'd1) || (req_op == 2'd2);
  assign b_sgn = (req_op == 2'd1);
  assign a_ext = {{2{a_sgn & req_a[XLEN-1]}}, req_a};
  assign b_ext = {{2{b_sgn & req_b[XLEN-1]}}, req_b};

  assign accept = req_valid & req_ready;
  assign rsp_hs = rsp_valid & rsp_ready & ~flush;
  // Result is taken only when it belongs to a live, unflushed op.
  assign cap    = (state_q == WAIT) & core_done & ~flush;

  // Extended operands fit in 2*XLEN bits, so the top bits are pure sign.
  assign prod_lo     = core_product[XLEN-1:0];
  assign prod_hi     = core_product[2*XLEN-1:XLEN];
  assign unused_prod = ^core_product[2*CORE_W-1:2*XLEN];

`ifdef MUL_RESULT_CACHE_EN
  logic              c_vld;
  logic              c_as;
  logic              c_bs;
  logic              as_q;
  logic              bs_q;
  logic [XLEN-1:0]   c_a;
  logic [XLEN-1:0]   c_b;
  logic [2*XLEN-1:0] c_prod;
  logic [2*XLEN-1:0] prod_q;

  // MUL only uses the low half, which is sign-mode independent.
  assign hit = c_vld
            && (req_a == c_a)
            && (req_b == c_b)
            && (((a_sgn == c_as) && (b_sgn == c_bs))
                || (req_op == 2'd0));

  assign hit_data = (req_op == 2'd0)
                  ? c_prod[XLEN-1:0]
                  : c_prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_vld  <= 1'b0;
      c_as   <= 1'b0;
      c_bs   <= 1'b0;
      c_a    <= '0;
      c_b    <= '0;
      c_prod <= '0;
      as_q   <= 1'b0;
      bs_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      if (accept) begin
        // A hit keeps the cached sign modes so the
        // re-commit below stays self-consistent.
        if (hit) begin
          as_q   <= c_as;
          bs_q   <= c_bs;
          prod_q <= c_prod;
        end else begin
          as_q <= a_sgn;
          bs_q <= b_sgn;
        end
      end
      if (cap) begin
        prod_q <= core_product[2*XLEN-1:0];
      end
      // Commit only once the response leaves unflushed.
      if (rsp_hs) begin
        c_vld  <= 1'b1;
        c_a    <= core_a[XLEN-1:0];
        c_b    <= core_b[XLEN-1:0];
        c_as   <= as_q;
        c_bs   <= bs_q;
        c_prod <= prod_q;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = hit ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        state_d = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (core_done) begin
          state_d = flush ? IDLE : RESP;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        if (flush || rsp_ready) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (core_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_a   <= '0;
      core_b   <= '0;
      rsp_data <= '0;
      rsp_tag  <= '0;
      lo_q     <= 1'b0;
    end else begin
      if (accept) begin
        core_a  <= a_ext;
        core_b  <= b_ext;
        rsp_tag <= req_tag;
        lo_q    <= (req_op == 2'd0);
        if (hit) begin
          rsp_data <= hit_data;
        end
      end
      if (cap) begin
        rsp_data <= lo_q ? prod_lo : prod_hi;
      end
    end
  end

endmodule
